// File: rtl/soc_bram_arb.sv
// soc_bram_arb: round-robin arbiter sharing one 32-bit BRAM controller between fetch (0) and data (1) ports.
// Define SOC_BRAM_ARB_TIMEOUT_EN to add a downstream ack timeout that completes with o_err and all-ones data.
module soc_bram_arb #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb0,
    input  logic [AW-1:0] i_addr0,
    input  logic          i_rw0,
    input  logic [31:0]   i_dwrite0,
    output logic          o_ack0,
    output logic [31:0]   o_dread0,
    input  logic          i_stb1,
    input  logic [AW-1:0] i_addr1,
    input  logic          i_rw1,
    input  logic [31:0]   i_dwrite1,
    output logic          o_ack1,
    output logic [31:0]   o_dread1,
    output logic          o_stb,
    output logic [AW-1:0] o_addr,
    output logic          o_rw,
    output logic [31:0]   o_dwrite,
    input  logic          i_ack,
    input  logic [31:0]   i_dread,
    output logic          o_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic          stb_q, stb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [31:0]   dwrite_q, dwrite_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [31:0]   dread0_q, dread0_d;
    logic [31:0]   dread1_q, dread1_d;
    logic          pick;

`ifdef SOC_BRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout;
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));
`else
    // Keeps the timeout parameter referenced when the feature is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Arbitration, transaction sequencing and completion capture.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        stb_d    = 1'b0;
        addr_d   = addr_q;
        rw_d     = rw_q;
        dwrite_d = dwrite_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        dread0_d = dread0_q;
        dread1_d = dread1_q;
        pick     = 1'b0;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_stb0 || i_stb1) begin
                    pick     = (i_stb0 && i_stb1) ? ~last_q : i_stb1;
                    gnt_d    = pick;
                    last_d   = pick;
                    addr_d   = pick ? i_addr1 : i_addr0;
                    rw_d     = pick ? i_rw1 : i_rw0;
                    dwrite_d = pick ? i_dwrite1 : i_dwrite0;
                    stb_d    = 1'b1;
                    state_d  = S_REQ;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            S_REQ, S_WAIT: begin
                state_d = S_WAIT;
                if (i_ack) begin
                    if (gnt_q) begin
                        dread1_d = i_dread;
                        ack1_d   = 1'b1;
                    end else begin
                        dread0_d = i_dread;
                        ack0_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
                else if (timeout) begin
                    if (gnt_q) begin
                        dread1_d = 32'hFFFF_FFFF;
                        ack1_d   = 1'b1;
                    end else begin
                        dread0_d = 32'hFFFF_FFFF;
                        ack0_d   = 1'b1;
                    end
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset restores port 0 priority on the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            stb_q    <= 1'b0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            dwrite_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            dread0_q <= '0;
            dread1_q <= '0;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            stb_q    <= stb_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            dwrite_q <= dwrite_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            dread0_q <= dread0_d;
            dread1_q <= dread1_d;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign o_stb    = stb_q;
    assign o_addr   = addr_q;
    assign o_rw     = rw_q;
    assign o_dwrite = dwrite_q;
    assign o_ack0   = ack0_q;
    assign o_ack1   = ack1_q;
    assign o_dread0 = dread0_q;
    assign o_dread1 = dread1_q;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
    assign o_err    = err_q;
`else
    assign o_err    = 1'b0;
`endif

endmodule

// File: tb/tb_soc_bram_arb.sv
// tb_soc_bram_arb: directed and randomized bench for soc_bram_arb.
// Transaction-level model predicts grant order, bus contents, completion timing and read data.
module tb_soc_bram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rq_stb  [2];
    logic [7:0]  rq_addr [2];
    logic        rq_rw   [2];
    logic [31:0] rq_dw   [2];
    logic        ack0, ack1, o_err, o_stb, o_rw, i_ack;
    logic [31:0] dr0, dr1, o_dw, i_dread;
    logic [7:0]  o_addr;
    wire  [1:0]  acks = {ack1, ack0};

    soc_bram_arb #(.AW(8), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_stb0(rq_stb[0]), .i_addr0(rq_addr[0]), .i_rw0(rq_rw[0]),
        .i_dwrite0(rq_dw[0]), .o_ack0(ack0), .o_dread0(dr0),
        .i_stb1(rq_stb[1]), .i_addr1(rq_addr[1]), .i_rw1(rq_rw[1]),
        .i_dwrite1(rq_dw[1]), .o_ack1(ack1), .o_dread1(dr1),
        .o_stb(o_stb), .o_addr(o_addr), .o_rw(o_rw), .o_dwrite(o_dw),
        .i_ack(i_ack), .i_dread(i_dread), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Downstream controller: memory plus configurable ack delay.
    // rsp_mode: -1 random delay with spurious acks, -2 never ack, else fixed delay.
    int          rsp_mode = 1;
    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];

    initial begin
        int d;
        i_ack   = 1'b0;
        i_dread = '0;
        forever begin
            @(posedge clk); #1;
            i_ack   = 1'b0;
            i_dread = $urandom;
            if (o_stb && rsp_mode != -2) begin
                d = (rsp_mode == -1) ? $urandom_range(0, 4) : rsp_mode;
                repeat (d) begin
                    @(posedge clk); #1;
                    i_dread = $urandom;
                end
                i_ack = 1'b1;
                if (o_rw) dmem[o_addr] = o_dw;
                else i_dread = dmem[o_addr];
            end else if (!o_stb && rsp_mode == -1 && $urandom_range(0, 9) == 0) begin
                i_ack = 1'b1;
            end
        end
    end

    // Reference model: predicts grants, bus contents and completions each cycle.
    bit          busy = 0, ackpend = 0, ap = 0, rstp = 1, experr = 0;
    int          gport = 0, last = 1, wcnt = 0, sa = 100, e = 0;
    logic [7:0]  laddr = '0;
    logic        lrw = 1'b0;
    logic [31:0] ldw = '0, expd = '0, refval = '0;
    logic [31:0] hold [2];
    logic [1:0]  pstb = '0;
    logic [7:0]  paddr [2];
    logic        prw   [2];
    logic [31:0] pdw   [2];
    int          glog [$];

    initial begin
        forever begin
            @(negedge clk);
            if (rstp) begin
                check("rst_ctl", {o_stb, ack0, ack1, o_err, o_rw, o_addr}, '0);
                check("rst_dw", o_dw, '0);
                check("rst_dr", {dr0, dr1}, '0);
                busy = 0; ackpend = 0; last = 1; sa = 100;
                hold[0] = '0; hold[1] = '0;
                laddr = '0; lrw = 1'b0; ldw = '0;
            end else begin
                ap = ackpend;
                ackpend = 0;
                check("ack0", ack0, ap && gport == 0);
                check("ack1", ack1, ap && gport == 1);
                check("err", o_err, ap && experr);
                if (ap) begin
                    hold[gport] = expd;
                    sa = 0;
                end else if (sa < 100) begin
                    sa++;
                end
                check("dread0", dr0, hold[0]);
                check("dread1", dr1, hold[1]);
                if (o_stb) begin
                    check("stb_idle", busy || sa < 2, 0);
                    if (!busy) begin
                        e = (pstb == 2'b11) ? 1 - last : (pstb[1] ? 1 : 0);
                        check("stb_req", pstb != 2'b00, 1);
                        check("g_addr", o_addr, paddr[e]);
                        check("g_rw", o_rw, prw[e]);
                        if (prw[e]) check("g_dw", o_dw, pdw[e]);
                        busy = 1; gport = e; last = e; wcnt = 0;
                        glog.push_back(e);
                        laddr = o_addr; lrw = o_rw; ldw = o_dw;
                        if (lrw) ref_mem[laddr] = ldw;
                        else refval = ref_mem[laddr];
                    end
                end
                check("hold_bus", {o_rw, o_addr, o_dw}, {lrw, laddr, ldw});
                if (busy) begin
                    if (i_ack) begin
                        ackpend = 1; experr = 0; busy = 0;
                        expd = lrw ? i_dread : refval;
                    end else begin
                        wcnt++;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
                        if (wcnt == 15) begin
                            ackpend = 1; experr = 1; busy = 0;
                            expd = 32'hFFFF_FFFF;
                        end
`endif
                    end
                end
            end
            rstp  = rst;
            pstb  = {rq_stb[1], rq_stb[0]};
            paddr = rq_addr;
            prw   = rq_rw;
            pdw   = rq_dw;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        dmem[a]    = v;
        ref_mem[a] = v;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rq_stb[0] = 1'b0;
        rq_stb[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One requester transaction; lat counts cycles from strobe raise to ack.
    task automatic do_req(input int p, input logic [7:0] a, input logic rw,
                          input logic [31:0] d, output logic [31:0] rd,
                          output int lat, input bit keep);
        bit got;
        got = 0; lat = 0; rd = '0;
        @(posedge clk); #1;
        rq_stb[p] = 1'b1; rq_addr[p] = a; rq_rw[p] = rw; rq_dw[p] = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (acks[p]) begin
                got = 1;
                rd = (p == 1) ? dr1 : dr0;
            end
        end
        check("req_ack", got, 1);
        if (!keep) begin
            @(posedge clk); #1;
            rq_stb[p] = 1'b0;
        end
    endtask

    task automatic rr_port(input int p);
        logic [31:0] rd;
        int lat;
        for (int k = 0; k < 4; k++)
            do_req(p, 8'h80 | 8'(p * 4 + k * 8), p[0], $urandom, rd, lat, k < 3);
    endtask

    task automatic rand_port(input int p);
        logic [31:0] rd;
        logic [7:0]  a;
        int lat, gap;
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 3);
            a = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
            do_req(p, a, 1'($urandom_range(0, 1)), $urandom, rd, lat,
                   gap == 0 && k < 39);
            if (gap > 1) repeat (gap - 1) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd2;
        int lat, lat2, nack;
        bit seen;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq_stb[i] = 1'b0; rq_addr[i] = '0; rq_rw[i] = 1'b0; rq_dw[i] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        preload(8'h10, 32'hDEAD_BEEF);
        glog.delete();
        do_req(0, 8'h10, 1'b0, '0, rd, lat, 0);
        check("t1_data", rd, 32'hDEAD_BEEF);
        check("t1_lat", lat, 4);
        check("t1_grants", glog.size(), 1);

        do_reset();
        glog.delete();
        preload(8'h04, 32'h0BAD_F00D);
        fork
            do_req(0, 8'h04, 1'b0, '0, rd, lat, 0);
            do_req(1, 8'h21, 1'b1, 32'h1234_5678, rd2, lat2, 0);
        join
        check("t2_rd", rd, 32'h0BAD_F00D);
        check("t2_n", glog.size(), 2);
        check("t2_first", glog[0], 0);
        check("t2_second", glog[1], 1);
        check("t2_mem", dmem[8'h21], 32'h1234_5678);

        do_reset();
        glog.delete();
        fork
            rr_port(0);
            rr_port(1);
        join
        check("t3_n", glog.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_order", glog[i], i % 2);

        rsp_mode = 5;
        preload(8'h5C, 32'hA5A5_0F0F);
        do_req(1, 8'h5C, 1'b0, '0, rd, lat, 0);
        check("t4_data", rd, 32'hA5A5_0F0F);
        check("t4_lat", lat, 8);

        rsp_mode = 2;
        preload(8'h30, 32'h1111_2222);
        @(posedge clk); #1;
        rq_stb[0] = 1'b1; rq_addr[0] = 8'h30; rq_rw[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_stb;
        end
        check("t5_stb", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        rq_stb[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (acks != 2'b00 || o_stb) nack++;
        end
        check("t5_stale", nack, 0);

`ifdef SOC_BRAM_ARB_TIMEOUT_EN
        rsp_mode = -2;
        do_req(0, 8'h40, 1'b0, '0, rd, lat, 0);
        check("t6_data", rd, 32'hFFFF_FFFF);
        check("t6_lat", lat, 17);
        rsp_mode = 1;
        preload(8'h44, 32'hCAFE_F00D);
        do_req(0, 8'h44, 1'b0, '0, rd, lat, 0);
        check("t6_next", rd, 32'hCAFE_F00D);
`endif

        rsp_mode = -1;
        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_bram_arb.md
Name: soc_bram_arb

Overview:
- Two-port arbiter that shares one byte-addressable 32-bit BRAM controller between an instruction-fetch port (port 0) and a data load/store port (port 1).
- Accepts level-held strobe requests from each port and grants them round-robin.
- Issues one registered single-cycle strobe per transaction downstream.
- Returns the read word and a one-cycle ack to the granted port.
- Sits between the CPU bus masters and the BRAM controller in the SoC.

Parameters:
- AW, 8: byte address width shared by both ports and the downstream controller.
- TIMEOUT, 15: cycles to wait for downstream ack before an error completion; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_stb0  in  1  port 0 request; held high until o_ack0
- i_addr0  in  AW  port 0 byte address
- i_rw0  in  1  port 0 direction (1 = write)
- i_dwrite0  in  32  port 0 write data
- o_ack0  out  1  port 0 completion pulse
- o_dread0  out  32  port 0 read data; valid while o_ack0 is high
- i_stb1, i_addr1, i_rw1, i_dwrite1, o_ack1, o_dread1: same as port 0, for port 1
- o_stb  out  1  downstream strobe
- o_addr  out  AW  downstream address
- o_rw  out  1  downstream direction
- o_dwrite  out  32  downstream write data
- i_ack  in  1  downstream ack
- i_dread  in  32  downstream read data; valid while i_ack is high
- o_err  out  1  timeout completion flag; pulses with o_ackN

Behaviour:
- Reset is i_reset, synchronous, active-high; clock is i_clk.
- Reset values: o_stb, o_ack0, o_ack1 and o_err are 0. o_addr, o_rw, o_dwrite, o_dread0 and o_dread1 are 0. State is IDLE. Last-grant pointer is 1, so port 0 wins the first tie.
- State IDLE:
  - If no i_stbN is high, stay in IDLE.
  - If exactly one i_stbN is high, grant that port.
  - If both are high, grant the port opposite the last-grant pointer.
  - On a grant: latch that port's addr, rw and dwrite into o_addr/o_rw/o_dwrite, set o_stb=1, record the grant and update the pointer, go to REQ.
- State REQ: o_stb=1 for exactly this one cycle (cleared on leaving). Go to WAIT.
  - If i_ack is already high in REQ, treat it as in WAIT.
- State WAIT: on i_ack, capture i_dread into o_dreadG (G = granted port) and go to DONE. No other ack source exists.
- State DONE:
  - o_ackG=1 for one cycle and o_dreadG holds the captured word; o_ack of the other port stays 0.
  - Requests are not sampled in DONE, so the just-completed strobe is never re-granted.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle N; o_stb high in cycle N+1; downstream ack at N+2 (one-cycle controller); o_ackG at N+3. Back-to-back throughput is one transaction per 4 cycles.
- o_dreadN holds its value between acks. Writes also return the captured i_dread, which requesters ignore.
- o_addr, o_rw and o_dwrite stay stable from grant until the next grant, so they meet the downstream stable-address contract.
- i_ack seen in IDLE or DONE (spurious) is ignored.
- A requester dropping i_stb after grant does not cancel the transaction; the ack is still issued.
- Reset mid-transaction returns to IDLE with all outputs cleared. The pending downstream ack, if any, is ignored next cycle.
- Fairness: if both ports request continuously, grants alternate 0,1,0,1.

Optional Feature:
- Macro: SOC_BRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no i_ack, go to DONE with o_dreadG = 32'hFFFFFFFF and o_err=1 for the ack cycle.
  - A late i_ack after a timeout is ignored.
- Undefined: no counter; WAIT persists until i_ack; o_err is tied to 0.

Test Plan:
- Port 0 read, addr 8'h10, downstream returns 32'hDEADBEEF one cycle after o_stb -> o_stb single pulse with o_addr=8'h10, o_rw=0; o_ack0 at cycle N+3 with o_dread0=32'hDEADBEEF; o_ack1 stays 0.
- Both ports raise stb in the same cycle after reset (port 0 addr 8'h04 read, port 1 addr 8'h21 write 32'h12345678) -> port 0 is served first, then port 1; second o_stb has o_addr=8'h21, o_rw=1, o_dwrite=32'h12345678.
- Both ports hold stb for 4 transactions each -> grant order 0,1,0,1,0,1,0,1; exactly one ack per grant.
- Downstream ack delayed 5 cycles -> o_addr stable throughout; o_ack1 exactly one cycle after i_ack; no second o_stb issued.
- i_reset asserted in WAIT -> next cycle IDLE, all acks and o_stb are 0; a stale i_ack causes no ack.
- With SOC_BRAM_ARB_TIMEOUT_EN, TIMEOUT=15, never ack -> after 15 cycles o_ack0=1, o_err=1, o_dread0=32'hFFFFFFFF; the arbiter then serves the next request normally.
